// File: rtl/icache_refill_bridge_pkg.sv
// Shared types, widths and size helpers for the icache refill bridge.
package icache_refill_bridge_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned SIZE_W     = 3;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned MIN_SIZE   = 2;
  // Largest encodable size (7) is 128 bytes = 32 words, so 6 bits hold any beat count.
  localparam int unsigned BEAT_W     = 6;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  typedef struct packed {
    logic              error;
    logic [DATA_W-1:0] data;
  } beat_t;

  // Sub-word sizes behave as one word; oversize requests clamp to the largest supported line.
  function automatic logic [SIZE_W-1:0] eff_size(input logic [SIZE_W-1:0] size,
                                                 input int unsigned      maxSize);
    if (size < SIZE_W'(MIN_SIZE)) return SIZE_W'(MIN_SIZE);
    if (32'(size) > maxSize)      return SIZE_W'(maxSize);
    return size;
  endfunction

  function automatic logic [BEAT_W-1:0] beats_from_size(input logic [SIZE_W-1:0] size,
                                                        input int unsigned      maxSize);
    logic [SIZE_W-1:0] s;
    s = eff_size(size, maxSize);
    return BEAT_W'(1) << (s - SIZE_W'(MIN_SIZE));
  endfunction

endpackage

// File: rtl/icache_refill_bridge_if.sv
// Refill command, beat return and word-bus signals of the icache refill bridge.
interface icache_refill_bridge_if;
  import icache_refill_bridge_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_address;
  logic [SIZE_W-1:0] cmd_size;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_error;

  logic              bus_cmd_valid;
  logic              bus_cmd_ready;
  logic [ADDR_W-1:0] bus_cmd_address;
  logic              bus_rsp_valid;
  logic [DATA_W-1:0] bus_rsp_data;
  logic              bus_rsp_error;

  logic              busy;
  logic              unexpected_rsp;

  // Bridge side.
  modport slave (
    input  cmd_valid, cmd_address, cmd_size,
    input  bus_cmd_ready, bus_rsp_valid, bus_rsp_data, bus_rsp_error,
    output cmd_ready, rsp_valid, rsp_data, rsp_error,
    output bus_cmd_valid, bus_cmd_address, busy, unexpected_rsp
  );

  // Cache plus memory-bus side.
  modport master (
    output cmd_valid, cmd_address, cmd_size,
    output bus_cmd_ready, bus_rsp_valid, bus_rsp_data, bus_rsp_error,
    input  cmd_ready, rsp_valid, rsp_data, rsp_error,
    input  bus_cmd_valid, bus_cmd_address, busy, unexpected_rsp
  );

endinterface

// File: rtl/icache_refill_pending_ctr.sv
// Outstanding bus read counter: +1 per issued read, -1 per accepted response.
module icache_refill_pending_ctr #(
  parameter int unsigned MAX_PENDING = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic full_c,
  output logic empty_c
);

  localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);

  logic [PEND_W-1:0] count;

  // Simultaneous inc/dec leaves the count unchanged; the guards stop wrap in either direction.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !dec && !full_c) begin
      count <= count + PEND_W'(1);
    end else if (dec && !inc && !empty_c) begin
      count <= count - PEND_W'(1);
    end
  end

  assign full_c  = (count == PEND_W'(MAX_PENDING));
  assign empty_c = (count == '0);

endmodule

// File: rtl/icache_refill_bridge.sv
// Splits one icache line refill into single-word bus reads and streams the
// returned words back to the cache in order, one cycle after each bus response.
module icache_refill_bridge
  import icache_refill_bridge_pkg::*;
#(
  parameter int unsigned MAX_PENDING = 4,
  parameter int unsigned MAX_SIZE    = 6
) (
  input logic                  clk,
  input logic                  reset,
  icache_refill_bridge_if.slave port
);

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [BEAT_W-1:0] beats;
  logic [BEAT_W-1:0] issued;
  logic [BEAT_W-1:0] received;
  beat_t             rspBeat;
  logic              rspValid;
  logic              unexpectedRsp;

  logic              pendFull;
  logic              pendEmpty;
  logic              busFire;
  logic              rspAccept;
  logic              rspStray;
  logic [SIZE_W-1:0] cmdSize;

  icache_refill_pending_ctr #(
    .MAX_PENDING(MAX_PENDING)
  ) pendCtr (
    .clk    (clk),
    .reset  (reset),
    .inc    (busFire),
    .dec    (rspAccept),
    .full_c (pendFull),
    .empty_c(pendEmpty)
  );

  assign cmdSize   = eff_size(port.cmd_size, MAX_SIZE);
  assign busFire   = port.bus_cmd_valid && port.bus_cmd_ready;
  // A response with nothing outstanding (e.g. left over from before a reset) is never forwarded.
  assign rspAccept = port.bus_rsp_valid && !pendEmpty;
  assign rspStray  = port.bus_rsp_valid && pendEmpty;

  // Control and beat return state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      base          <= '0;
      beats         <= '0;
      issued        <= '0;
      received      <= '0;
      rspValid      <= 1'b0;
      rspBeat       <= '0;
      unexpectedRsp <= 1'b0;
    end else begin
      rspValid      <= rspAccept;
      unexpectedRsp <= rspStray;
      if (rspAccept) begin
        rspBeat  <= '{error: port.bus_rsp_error, data: port.bus_rsp_data};
        received <= received + BEAT_W'(1);
      end else begin
        rspBeat.error <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (port.cmd_valid) begin
            base     <= port.cmd_address & ~((ADDR_W'(1) << cmdSize) - ADDR_W'(1));
            beats    <= beats_from_size(port.cmd_size, MAX_SIZE);
            issued   <= '0;
            received <= '0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (busFire) begin
            issued <= issued + BEAT_W'(1);
            if (issued + BEAT_W'(1) == beats) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (received == beats) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Address and valid derive only from registers, so they hold while the bus stalls.
  assign port.bus_cmd_valid   = (state == ISSUE) && (issued < beats) && !pendFull;
  assign port.bus_cmd_address = base + ADDR_W'(issued) * ADDR_W'(WORD_BYTES);

  assign port.cmd_ready      = (state == IDLE) && !reset;
  assign port.rsp_valid      = rspValid;
  assign port.rsp_data       = rspBeat.data;
  assign port.rsp_error      = rspBeat.error;
  assign port.unexpected_rsp = unexpectedRsp;
  assign port.busy           = (state != IDLE) || rspValid;

endmodule
